// File: rtl/core_pkg.sv
// core_pkg: shared lane types for the VRF write-back path.
// Holds write-back source ids and the VRF write-word bundle.
package core_pkg;

  localparam int unsigned NrWbPorts = 3;
  localparam int unsigned VrfDataW  = 64;
  localparam int unsigned VrfAddrW  = 8;
  localparam int unsigned InsnIdW   = 3;

  typedef logic [VrfDataW-1:0]   vrf_data_t;
  typedef logic [VrfDataW/8-1:0] vrf_strb_t;
  typedef logic [VrfAddrW-1:0]   vrf_addr_t;
  typedef logic [InsnIdW-1:0]    insn_id_t;

  typedef enum logic [1:0] {
    WB_VALU = 2'd0,
    WB_VMUL = 2'd1,
    WB_VLSU = 2'd2
  } wb_src_e;

  typedef struct packed {
    vrf_data_t data;
    vrf_strb_t strb;
    vrf_addr_t addr;
    insn_id_t  id;
  } vrf_wr_t;

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin pick.
// Rotates requests by the pointer, finds the lowest set bit, rotates back.
module rr_arb_pick #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int unsigned    w_off;
  int unsigned    w_sum;

  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_rot = w_dbl[N-1:0];
  end

  always_comb begin
    o_any = 1'b0;
    w_off = 0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && w_rot[i]) begin
        o_any = 1'b1;
        w_off = unsigned'(i);
      end
    end
  end

  // Undo the rotation: winner sits w_off places past the pointer.
  always_comb begin
    w_sum = 32'(i_ptr) + w_off;
    if (w_sum >= N) begin
      w_sum = w_sum - N;
    end
    o_idx = w_sum[IdxW-1:0];
    o_gnt = '0;
    if (o_any) begin
      o_gnt = N'(1) << o_idx;
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: shares one VRF write port among the lane result units.
// Round-robin grant, single registered output slot, per-source counters.
module vrf_wb_arbiter #(
  parameter  int unsigned NrWbPorts = core_pkg::NrWbPorts,
  parameter  int unsigned CntWidth  = 16,
  localparam int unsigned SrcW      = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrWbPorts-1:0]                  wb_valid_i,
  output logic [NrWbPorts-1:0]                  wb_gnt_o,
  input  core_pkg::vrf_data_t [NrWbPorts-1:0]   wb_wdata_i,
  input  core_pkg::vrf_strb_t [NrWbPorts-1:0]   wb_wstrb_i,
  input  core_pkg::vrf_addr_t [NrWbPorts-1:0]   wb_addr_i,
  input  core_pkg::insn_id_t  [NrWbPorts-1:0]   wb_id_i,
  output logic                                  vrf_wvalid_o,
  input  logic                                  vrf_wready_i,
  output core_pkg::vrf_data_t                   vrf_wdata_o,
  output core_pkg::vrf_strb_t                   vrf_wstrb_o,
  output core_pkg::vrf_addr_t                   vrf_waddr_o,
  output core_pkg::insn_id_t                    vrf_wid_o,
  output logic [SrcW-1:0]                       vrf_wsrc_o,
  output logic [NrWbPorts-1:0][CntWidth-1:0]    wr_cnt_o
);

  logic                              w_free;
  logic [NrWbPorts-1:0]              w_req;
  logic [NrWbPorts-1:0]              w_gnt;
  logic [SrcW-1:0]                   w_idx;
  logic [SrcW-1:0]                   w_nxt;
  logic                              w_any;

  logic                              r_wvalid;
  logic [SrcW-1:0]                   r_rr;
  logic [SrcW-1:0]                   r_src;
  core_pkg::vrf_wr_t                 r_wr;
  logic [NrWbPorts-1:0][CntWidth-1:0] r_cnt;

  // The slot can take a new word when empty or draining this cycle.
  assign w_free = !r_wvalid || vrf_wready_i;
  assign w_req  = (rst_ni && w_free) ? wb_valid_i : '0;

  rr_arb_pick #(
    .N (NrWbPorts)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_nxt = (w_idx == SrcW'(NrWbPorts - 1)) ? '0
               : w_idx + SrcW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wvalid <= 1'b0;
      r_rr     <= '0;
      r_cnt    <= '0;
    end else if (w_any) begin
      r_wvalid     <= 1'b1;
      r_rr         <= w_nxt;
      r_cnt[w_idx] <= r_cnt[w_idx] + CntWidth'(1);
    end else if (vrf_wready_i) begin
      r_wvalid <= 1'b0;
    end
  end

  // Payload is only meaningful while r_wvalid is set, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_any) begin
      r_wr <= '{
        data: wb_wdata_i[w_idx],
        strb: wb_wstrb_i[w_idx],
        addr: wb_addr_i[w_idx],
        id:   wb_id_i[w_idx]
      };
      r_src <= w_idx;
    end
  end

  assign wb_gnt_o     = w_gnt;
  assign vrf_wvalid_o = r_wvalid;
  assign vrf_wdata_o  = r_wr.data;
  assign vrf_wstrb_o  = r_wr.strb;
  assign vrf_waddr_o  = r_wr.addr;
  assign vrf_wid_o    = r_wr.id;
  assign vrf_wsrc_o   = r_src;
  assign wr_cnt_o     = r_cnt;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0(wb_gnt_o));

  a_gnt_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (wb_gnt_o & ~wb_valid_i) == '0);

  a_stall_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (r_wvalid && !vrf_wready_i) |=>
      (r_wvalid && $stable(r_wr) && $stable(r_src)));
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed vectors, grants checked inline,
// written words checked by a queue-based monitor.
`timescale 1ns/1ps
module tb_vrf_wb_arbiter;
  import core_pkg::*;

  localparam int unsigned N  = NrWbPorts;
  localparam int unsigned CW = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0]         wb_valid_i;
  logic [N-1:0]         wb_gnt_o;
  vrf_data_t [N-1:0]    wb_wdata_i;
  vrf_strb_t [N-1:0]    wb_wstrb_i;
  vrf_addr_t [N-1:0]    wb_addr_i;
  insn_id_t  [N-1:0]    wb_id_i;
  logic                 vrf_wvalid_o;
  logic                 vrf_wready_i;
  vrf_data_t            vrf_wdata_o;
  vrf_strb_t            vrf_wstrb_o;
  vrf_addr_t            vrf_waddr_o;
  insn_id_t             vrf_wid_o;
  logic [1:0]           vrf_wsrc_o;
  logic [N-1:0][CW-1:0] wr_cnt_o;

  typedef struct packed {
    logic [1:0] src;
    vrf_data_t  data;
    vrf_strb_t  strb;
    vrf_addr_t  addr;
    insn_id_t   id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  vrf_wb_arbiter #(
    .NrWbPorts (N),
    .CntWidth  (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wb_valid_i   (wb_valid_i),
    .wb_gnt_o     (wb_gnt_o),
    .wb_wdata_i   (wb_wdata_i),
    .wb_wstrb_i   (wb_wstrb_i),
    .wb_addr_i    (wb_addr_i),
    .wb_id_i      (wb_id_i),
    .vrf_wvalid_o (vrf_wvalid_o),
    .vrf_wready_i (vrf_wready_i),
    .vrf_wdata_o  (vrf_wdata_o),
    .vrf_wstrb_o  (vrf_wstrb_o),
    .vrf_waddr_o  (vrf_waddr_o),
    .vrf_wid_o    (vrf_wid_o),
    .vrf_wsrc_o   (vrf_wsrc_o),
    .wr_cnt_o     (wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted write must match the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && vrf_wvalid_o && vrf_wready_i) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_write", 64'(q.size()), 64'(1));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_src",  64'(vrf_wsrc_o),  64'(e.src));
        chk("sb_data", 64'(vrf_wdata_o), 64'(e.data));
        chk("sb_strb", 64'(vrf_wstrb_o), 64'(e.strb));
        chk("sb_addr", 64'(vrf_waddr_o), 64'(e.addr));
        chk("sb_id",   64'(vrf_wid_o),   64'(e.id));
      end
    end
  end

  task automatic setp(input int k, input logic v,
                      input vrf_data_t d, input vrf_addr_t a);
    wb_valid_i[k] = v;
    wb_wdata_i[k] = d;
    wb_wstrb_i[k] = d[7:0];
    wb_addr_i[k]  = a;
    wb_id_i[k]    = insn_id_t'(a[2:0] ^ 3'(k));
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) setp(k, 1'b0, '0, '0);
  endtask

  // One cycle: drive, check grant at negedge, queue the expected word.
  task automatic step(input logic rdy, input logic [N-1:0] eg,
                      input string nm);
    exp_t e;
    vrf_wready_i = rdy;
    @(negedge clk_i);
    chk(nm, 64'(wb_gnt_o), 64'(eg));
    for (int k = 0; k < N; k++) begin
      if (eg[k]) begin
        e.src  = 2'(k);
        e.data = wb_wdata_i[k];
        e.strb = wb_wstrb_i[k];
        e.addr = wb_addr_i[k];
        e.id   = wb_id_i[k];
        q.push_back(e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_all();
    vrf_wready_i = 1'b1;
    q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_all();
    vrf_wready_i = 1'b1;
    #12;
    chk("rst_wvalid", 64'(vrf_wvalid_o), 64'(0));
    chk("rst_gnt",    64'(wb_gnt_o),     64'(0));
    chk("rst_cnt",    64'(wr_cnt_o),     64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single requester streaming four words.
    for (int i = 0; i < 4; i++) begin
      setp(0, 1'b1, 64'hA000 + 64'(i), 8'(8'h10 + i));
      step(1'b1, 3'b001, "t1_gnt");
      if (i == 0) chk("t1_lat", 64'(vrf_wvalid_o), 64'(1));
    end
    idle_all();
    step(1'b1, 3'b000, "t1_idle_gnt");
    chk("t1_drain", 64'(vrf_wvalid_o), 64'(0));
    chk("t1_cnt0",  64'(wr_cnt_o[0]),  64'(4));
    chk("t1_q",     64'(q.size()),     64'(0));

    // All three continuously valid from pointer 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++)
        setp(k, 1'b1, 64'hB000 + 64'(16 * k + i), 8'(8'h20 + 4 * k + i));
      step(1'b1, 3'b001 << (i % 3), "t2_gnt");
      chk("t2_src_lag", 64'(vrf_wsrc_o), 64'(i % 3));
    end
    idle_all();
    step(1'b1, 3'b000, "t2_idle_gnt");
    for (int k = 0; k < N; k++)
      chk("t2_cnt", 64'(wr_cnt_o[k]), 64'(2));
    chk("t2_q", 64'(q.size()), 64'(0));

    // Back-pressure with VMUL's word parked in the slot.
    do_reset();
    setp(1, 1'b1, 64'hDEAD, 8'h05);
    step(1'b1, 3'b010, "t3_gnt");
    setp(0, 1'b1, 64'hC0, 8'h40);
    setp(1, 1'b1, 64'hC1, 8'h41);
    setp(2, 1'b1, 64'hC2, 8'h42);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, "t3_stall_gnt");
      chk("t3_hold_v",    64'(vrf_wvalid_o), 64'(1));
      chk("t3_hold_data", 64'(vrf_wdata_o),  64'hDEAD);
      chk("t3_hold_addr", 64'(vrf_waddr_o),  64'h5);
      chk("t3_hold_src",  64'(vrf_wsrc_o),   64'(1));
    end
    step(1'b1, 3'b100, "t3_release_gnt");
    chk("t3_handoff_v",    64'(vrf_wvalid_o), 64'(1));
    chk("t3_handoff_data", 64'(vrf_wdata_o),  64'hC2);
    idle_all();
    step(1'b1, 3'b000, "t3_idle_gnt");
    chk("t3_drain", 64'(vrf_wvalid_o), 64'(0));
    chk("t3_q",     64'(q.size()),     64'(0));

    // Pointer wrap: move pointer to 2, then requests {0,2}.
    do_reset();
    setp(1, 1'b1, 64'hE1, 8'h50);
    step(1'b1, 3'b010, "t4_pre_gnt");
    setp(1, 1'b0, '0, '0);
    setp(0, 1'b1, 64'hE0, 8'h60);
    setp(2, 1'b1, 64'hE2, 8'h62);
    step(1'b1, 3'b100, "t4_wrap_gnt2");
    step(1'b1, 3'b001, "t4_wrap_gnt0");
    setp(0, 1'b0, '0, '0);
    setp(1, 1'b1, 64'hE3, 8'h51);
    step(1'b1, 3'b010, "t4_ptr1_gnt");
    idle_all();
    step(1'b1, 3'b000, "t4_idle_gnt");
    chk("t4_q", 64'(q.size()), 64'(0));

    // Idle drain after a single write.
    do_reset();
    setp(2, 1'b1, 64'hF0, 8'h70);
    step(1'b1, 3'b100, "t5_gnt");
    chk("t5_valid", 64'(vrf_wvalid_o), 64'(1));
    idle_all();
    step(1'b1, 3'b000, "t5_idle_gnt");
    chk("t5_drain", 64'(vrf_wvalid_o), 64'(0));
    chk("t5_cnt2",  64'(wr_cnt_o[2]),  64'(1));

    // Asynchronous reset while a write is stalled.
    do_reset();
    setp(0, 1'b1, 64'h99, 8'h07);
    step(1'b1, 3'b001, "t6_gnt");
    idle_all();
    step(1'b0, 3'b000, "t6_stall_gnt");
    chk("t6_stalled", 64'(vrf_wvalid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_drop", 64'(vrf_wvalid_o), 64'(0));
    q.delete();
    vrf_wready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    chk("t6_cnt_clr", 64'(wr_cnt_o), 64'(0));
    for (int k = 0; k < N; k++)
      setp(k, 1'b1, 64'h7700 + 64'(k), 8'(8'h30 + k));
    step(1'b1, 3'b001, "t6_rr0_gnt");
    idle_all();
    step(1'b1, 3'b000, "t6_idle_gnt");
    chk("t6_q", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
